// File: rtl/spatial_sequencer_pkg.sv
// Shared types and defaults for the spatial encoding sequencer.
// Optional feature macro: SPATIAL_SEQ_MOD_BIND_EN (second/final channel binding per modality).
package spatial_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  localparam int DEFAULT_MOD0_CHANNELS = 32;
  localparam int DEFAULT_MOD1_CHANNELS = 77;
  localparam int DEFAULT_MOD2_CHANNELS = 108;
  localparam int CHANNEL_IDX_WIDTH     = 8;

  function automatic int total_channels(input int mod0, input int mod1, input int mod2);
    return mod0 + mod1 + mod2;
  endfunction

endpackage

// File: rtl/spatial_sequencer_modality_tracker.sv
// Tracks which modality the global channel index sits in and flags its first/second/last channel.
// With SPATIAL_SEQ_MOD_BIND_EN undefined the local offset register is dropped and second is tied low.
module modality_tracker
  import spatial_sequencer_pkg::*;
#(
  parameter int MOD0_CHANNELS = DEFAULT_MOD0_CHANNELS,
  parameter int MOD1_CHANNELS = DEFAULT_MOD1_CHANNELS,
  parameter int MOD2_CHANNELS = DEFAULT_MOD2_CHANNELS,
  parameter int IDX_WIDTH     = CHANNEL_IDX_WIDTH
) (
  input  logic                 Clk_CI,
  input  logic                 Reset_RBI,
  input  logic                 inc,
  input  logic                 clr,
  input  logic [IDX_WIDTH-1:0] channel_idx,
  output logic [1:0]           modality_idx,
  output logic                 mod_first,
  output logic                 mod_second,
  output logic                 mod_last
);

  localparam int LAST_CHANNEL = total_channels(MOD0_CHANNELS, MOD1_CHANNELS, MOD2_CHANNELS) - 1;

  localparam logic [IDX_WIDTH-1:0] BASE1 = IDX_WIDTH'(MOD0_CHANNELS);
  localparam logic [IDX_WIDTH-1:0] BASE2 = IDX_WIDTH'(MOD0_CHANNELS + MOD1_CHANNELS);
  localparam logic [IDX_WIDTH-1:0] END0  = IDX_WIDTH'(MOD0_CHANNELS - 1);
  localparam logic [IDX_WIDTH-1:0] END1  = IDX_WIDTH'(MOD0_CHANNELS + MOD1_CHANNELS - 1);
  localparam logic [IDX_WIDTH-1:0] END2  = IDX_WIDTH'(LAST_CHANNEL);

  logic [1:0] modality_q;

  // Boundaries are fixed by the parameters, so they are decoded straight from the global index.
  assign mod_first    = (channel_idx == '0) || (channel_idx == BASE1) || (channel_idx == BASE2);
  assign mod_last     = (channel_idx == END0) || (channel_idx == END1) || (channel_idx == END2);
  assign modality_idx = modality_q;

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI || clr) begin
      modality_q <= 2'd0;
    end else if (inc && mod_last && (modality_q != 2'd2)) begin
      modality_q <= modality_q + 2'd1;
    end
  end

`ifdef SPATIAL_SEQ_MOD_BIND_EN
  logic [IDX_WIDTH-1:0] offset_q;

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI || clr) begin
      offset_q <= '0;
    end else if (inc) begin
      offset_q <= mod_last ? '0 : offset_q + 1'b1;
    end
  end

  assign mod_second = (offset_q == IDX_WIDTH'(1));
`else
  assign mod_second = 1'b0;
`endif

endmodule

// File: rtl/spatial_sequencer.sv
// Control FSM for the spatial encoding stage: walks all channels of one sample, then holds the result.
// Optional feature macro: SPATIAL_SEQ_MOD_BIND_EN enables the second/final-of-modality strobes.
module spatial_sequencer
  import spatial_sequencer_pkg::*;
#(
  parameter int MOD0_CHANNELS = DEFAULT_MOD0_CHANNELS,
  parameter int MOD1_CHANNELS = DEFAULT_MOD1_CHANNELS,
  parameter int MOD2_CHANNELS = DEFAULT_MOD2_CHANNELS,
  parameter int IDX_WIDTH     = CHANNEL_IDX_WIDTH
) (
  input  logic                 Clk_CI,
  input  logic                 Reset_RBI,
  input  logic                 ValidIn_SI,
  output logic                 ReadyOut_SO,
  input  logic                 FeatureValid_SI,
  output logic [IDX_WIDTH-1:0] ChannelIdx_DO,
  output logic [1:0]           ModalityIdx_DO,
  output logic                 AccEnable_SO,
  output logic                 AccFirst_SO,
  output logic                 AccStoreSecond_SO,
  output logic                 AccXorFinal_SO,
  output logic                 ValidOut_SO,
  input  logic                 ReadyIn_SI
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(total_channels(MOD0_CHANNELS, MOD1_CHANNELS, MOD2_CHANNELS) - 1);

  seq_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q;
  logic                 inc, clr;
  logic                 mod_first, mod_second, mod_last;

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The terminal channel moves to DONE without incrementing, so the index never wraps.
  always_comb begin
    state_d      = state_q;
    ReadyOut_SO  = 1'b0;
    AccEnable_SO = 1'b0;
    ValidOut_SO  = 1'b0;
    inc          = 1'b0;
    clr          = 1'b0;
    unique case (state_q)
      IDLE: begin
        ReadyOut_SO = 1'b1;
        if (ValidIn_SI) begin
          state_d = ACCUM;
          clr     = 1'b1;
        end
      end
      ACCUM: begin
        AccEnable_SO = FeatureValid_SI;
        if (FeatureValid_SI) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            inc = 1'b1;
          end
        end
      end
      DONE: begin
        ValidOut_SO = 1'b1;
        if (ReadyIn_SI) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI || clr) begin
      idx_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  modality_tracker #(
    .MOD0_CHANNELS(MOD0_CHANNELS),
    .MOD1_CHANNELS(MOD1_CHANNELS),
    .MOD2_CHANNELS(MOD2_CHANNELS),
    .IDX_WIDTH    (IDX_WIDTH)
  ) i_modality_tracker (
    .Clk_CI      (Clk_CI),
    .Reset_RBI   (Reset_RBI),
    .inc         (inc),
    .clr         (clr),
    .channel_idx (idx_q),
    .modality_idx(ModalityIdx_DO),
    .mod_first   (mod_first),
    .mod_second  (mod_second),
    .mod_last    (mod_last)
  );

  assign ChannelIdx_DO     = idx_q;
  assign AccFirst_SO       = AccEnable_SO && mod_first && (ModalityIdx_DO == 2'd0);
  assign AccStoreSecond_SO = AccEnable_SO && mod_second;
`ifdef SPATIAL_SEQ_MOD_BIND_EN
  assign AccXorFinal_SO    = AccEnable_SO && mod_last;
`else
  assign AccXorFinal_SO    = 1'b0;
`endif

endmodule

// File: tb/tb_spatial_sequencer.sv
// Self-checking bench for spatial_sequencer with modality sizes 3, 2, 4 (nine channels per sample).
// Follows SPATIAL_SEQ_MOD_BIND_EN for the expected second/final strobes.
module tb_spatial_sequencer;

  localparam int M0 = 3, M1 = 2, M2 = 4, N = M0 + M1 + M2, IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vin = 1'b0, fv = 1'b0, rin = 1'b0;
  logic          ready_out, acc_en, acc_first, acc_second, acc_final, valid_out;
  logic [IW-1:0] chan_idx;
  logic [1:0]    mod_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0=idle, 1=accumulating, 2=done.
  int   m_phase = 0, m_idx = 0;
  bit   m_known = 1'b0;
  int   first_mask, second_mask, final_mask;

  spatial_sequencer #(
    .MOD0_CHANNELS(M0), .MOD1_CHANNELS(M1), .MOD2_CHANNELS(M2), .IDX_WIDTH(IW)
  ) dut (
    .Clk_CI           (clk),
    .Reset_RBI        (rst_n),
    .ValidIn_SI       (vin),
    .ReadyOut_SO      (ready_out),
    .FeatureValid_SI  (fv),
    .ChannelIdx_DO    (chan_idx),
    .ModalityIdx_DO   (mod_idx),
    .AccEnable_SO     (acc_en),
    .AccFirst_SO      (acc_first),
    .AccStoreSecond_SO(acc_second),
    .AccXorFinal_SO   (acc_final),
    .ValidOut_SO      (valid_out),
    .ReadyIn_SI       (rin)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int modality_of(input int i);
    if (i < M0) return 0;
    if (i < M0 + M1) return 1;
    return 2;
  endfunction

  function automatic int offset_of(input int i);
    int m = modality_of(i);
    return (m == 0) ? i : (m == 1) ? i - M0 : i - M0 - M1;
  endfunction

  function automatic int size_of(input int i);
    int m = modality_of(i);
    return (m == 0) ? M0 : (m == 1) ? M1 : M2;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_idx = 0; m_known = 1'b1;
    end else if (m_known) begin
      case (m_phase)
        0: if (vin) begin m_phase = 1; m_idx = 0; end
        1: if (fv) begin
             if (m_idx == N - 1) m_phase = 2;
             else m_idx++;
           end
        default: if (rin) begin m_phase = 0; m_idx = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      automatic bit en = (m_phase == 1) && fv;
      automatic int exp_second = 0, exp_final = 0;
`ifdef SPATIAL_SEQ_MOD_BIND_EN
      exp_second = (en && offset_of(m_idx) == 1) ? 1 : 0;
      exp_final  = (en && offset_of(m_idx) == size_of(m_idx) - 1) ? 1 : 0;
`endif
      check_output("ready_out", int'(ready_out), int'(m_phase == 0));
      check_output("valid_out", int'(valid_out), int'(m_phase == 2));
      check_output("acc_en",    int'(acc_en),    int'(en));
      check_output("acc_first", int'(acc_first), int'(en && m_idx == 0));
      check_output("acc_second", int'(acc_second), exp_second);
      check_output("acc_final",  int'(acc_final),  exp_final);
      if (m_phase != 2) begin
        check_output("chan_idx", int'(chan_idx), m_idx);
        check_output("mod_idx",  int'(mod_idx),  modality_of(m_idx));
      end
      if (acc_en) begin
        if (acc_first)  first_mask  |= (1 << chan_idx);
        if (acc_second) second_mask |= (1 << chan_idx);
        if (acc_final)  final_mask  |= (1 << chan_idx);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accepts one sample and returns edges from the accept edge (inclusive) to ValidOut rising.
  task automatic apply_stimulus(input int stall_at, input int stall_len, output int lat);
    int guard = 0;
    int stalled = 0;
    while (!ready_out && guard < 50) begin tick(); guard++; end
    check_output("ready_before_accept", int'(ready_out), 1);
    first_mask = 0; second_mask = 0; final_mask = 0;
    vin = 1'b1; fv = 1'b1;
    tick();
    vin = 1'b0; lat = 1;
    while (!valid_out && lat < 100) begin
      if (int'(chan_idx) == stall_at && stalled < stall_len) begin
        fv = 1'b0; stalled++;
        #1;
        check_output("stall_idx", int'(chan_idx), stall_at);
        check_output("stall_en",  int'(acc_en), 0);
      end else begin
        fv = 1'b1;
      end
      tick(); lat++;
    end
    check_output("valid_reached", int'(valid_out), 1);
  endtask

  task automatic check_masks();
    check_output("first_mask", first_mask, 9'b000000001);
`ifdef SPATIAL_SEQ_MOD_BIND_EN
    check_output("second_mask", second_mask, 9'b001010010);
    check_output("final_mask",  final_mask,  9'b100010100);
`else
    check_output("second_mask", second_mask, 0);
    check_output("final_mask",  final_mask,  0);
`endif
  endtask

  task automatic release_done();
    rin = 1'b1;
    tick();
    rin = 1'b0;
    check_output("release_ready", int'(ready_out), 1);
    check_output("release_idx",   int'(chan_idx), 0);
    check_output("release_mod",   int'(mod_idx), 0);
  endtask

  initial begin
    int lat;
    int accepts[$];
    tick(); tick();
    check_output("reset_ready", int'(ready_out), 1);
    check_output("reset_valid", int'(valid_out), 0);
    check_output("reset_idx",   int'(chan_idx), 0);
    check_output("reset_en",    int'(acc_en), 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single sample, no stalls");
    apply_stimulus(-1, 0, lat);
    check_output("latency_plain", lat, 10);
    check_masks();
    release_done();

    $display("[TB] two stall cycles at index 3");
    apply_stimulus(3, 2, lat);
    check_output("latency_stall", lat, 12);
    check_masks();

    $display("[TB] hold in DONE for 5 cycles");
    for (int i = 0; i < 5; i++) begin
      check_output("done_hold_valid", int'(valid_out), 1);
      check_output("done_hold_en",    int'(acc_en), 0);
      tick();
    end
    release_done();

    $display("[TB] reset at index 5");
    vin = 1'b1; fv = 1'b1;
    tick();
    vin = 1'b0;
    for (int i = 0; i < 20 && int'(chan_idx) != 5; i++) tick();
    check_output("reached_idx5", int'(chan_idx), 5);
    rst_n = 1'b0;
    tick();
    check_output("rst_ready",  int'(ready_out), 1);
    check_output("rst_idx",    int'(chan_idx), 0);
    check_output("rst_en",     int'(acc_en), 0);
    check_output("rst_first",  int'(acc_first), 0);
    check_output("rst_second", int'(acc_second), 0);
    check_output("rst_final",  int'(acc_final), 0);
    check_output("rst_valid",  int'(valid_out), 0);
    rst_n = 1'b1;
    apply_stimulus(-1, 0, lat);
    check_output("latency_after_reset", lat, 10);
    check_masks();
    release_done();

    $display("[TB] back-to-back samples");
    vin = 1'b1; rin = 1'b1; fv = 1'b1;
    for (int k = 0; k < 45; k++) begin
      if (ready_out) accepts.push_back(k);
      tick();
    end
    vin = 1'b0; rin = 1'b0;
    check_output("b2b_accept_count", accepts.size(), 5);
    for (int i = 1; i < accepts.size(); i++)
      check_output("b2b_spacing", accepts[i] - accepts[i-1], 11);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
